// File: rtl/fft_peak_detect.sv
// Scans a captured 16-bin complex FFT frame one bin per cycle and reports the bin with the largest squared magnitude.
// Optional feature macro PEAK_MAG_EN: adds the peak_mag output carrying the winning squared magnitude.
module fft_peak_detect #(
   parameter int CW = 16,
   parameter int MW = 2*CW+1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2*CW-1:0] fft_d0,
   input  logic [2*CW-1:0] fft_d1,
   input  logic [2*CW-1:0] fft_d2,
   input  logic [2*CW-1:0] fft_d3,
   input  logic [2*CW-1:0] fft_d4,
   input  logic [2*CW-1:0] fft_d5,
   input  logic [2*CW-1:0] fft_d6,
   input  logic [2*CW-1:0] fft_d7,
   input  logic [2*CW-1:0] fft_d8,
   input  logic [2*CW-1:0] fft_d9,
   input  logic [2*CW-1:0] fft_d10,
   input  logic [2*CW-1:0] fft_d11,
   input  logic [2*CW-1:0] fft_d12,
   input  logic [2*CW-1:0] fft_d13,
   input  logic [2*CW-1:0] fft_d14,
   input  logic [2*CW-1:0] fft_d15,
   input  logic          fft_valid,
   output logic [3:0]    freq,
   output logic          done,
   output logic          busy,
   output logic          overrun
`ifdef PEAK_MAG_EN
   ,
   output logic [MW-1:0] peak_mag
`endif
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t          state, next_state;
   logic [3:0]      idx;
   logic [MW-1:0]   best;
   logic [3:0]      best_idx;
   logic [2*CW-1:0] in_words [16];
   logic [2*CW-1:0] frame [16];

   logic            capture, eval, finish, upd;
   logic [MW-1:0]   cur_mag, win_mag;
   logic [3:0]      win_idx;

   // Squares of two signed components; each square is non-negative, so the sum
   // is exact in MW bits even for two most-negative components (2^(2CW-1)).
   function automatic logic [MW-1:0] sq_mag(input logic [2*CW-1:0] w);
      logic signed [CW-1:0]   re, im;
      logic signed [2*CW-1:0] pr, pi;
      re = w[2*CW-1:CW];
      im = w[CW-1:0];
      pr = re * re;
      pi = im * im;
      return MW'($unsigned(pr)) + MW'($unsigned(pi));
   endfunction

   assign in_words = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                       fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (fft_valid) next_state = SCAN;
         SCAN:    if (idx == 4'd15 && !fft_valid) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Back-to-back acceptance: the last scan cycle may also capture the next frame.
   always_comb begin
      eval    = (state == SCAN);
      finish  = eval && (idx == 4'd15);
      capture = fft_valid && ((state == IDLE) || finish);
   end

   always_comb begin
      cur_mag = sq_mag(frame[idx]);
      upd     = (idx == 4'd0) || (cur_mag > best);
      win_mag = upd ? cur_mag : best;
      win_idx = upd ? idx : best_idx;
   end

   always_ff @(posedge clk) begin
      if (capture) frame <= in_words;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= 4'd0;
         best     <= '0;
         best_idx <= 4'd0;
         freq     <= 4'd0;
         done     <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
`ifdef PEAK_MAG_EN
         peak_mag <= '0;
`endif
      end else begin
         done    <= finish;
         busy    <= (next_state == SCAN);
         overrun <= fft_valid && eval && (idx != 4'd15);
         if (finish) begin
            freq     <= win_idx;
`ifdef PEAK_MAG_EN
            peak_mag <= win_mag;
`endif
         end
         if (capture) begin
            idx      <= 4'd0;
            best     <= '0;
            best_idx <= 4'd0;
         end else if (eval) begin
            idx      <= idx + 4'd1;
            best     <= win_mag;
            best_idx <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: single frames, ties, extreme values, back-to-back, overrun, mid-scan reset.
module tb_fft_peak_detect;
   localparam int CW = 16;
   localparam int MW = 2*CW+1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2*CW-1:0] d [16];
   logic          fft_valid = 1'b0;
   logic [3:0]    freq;
   logic          done, busy, overrun;
`ifdef PEAK_MAG_EN
   logic [MW-1:0] peak_mag;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fft_peak_detect #(.CW(CW), .MW(MW)) dut (
      .clk(clk), .rst(rst),
      .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
      .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
      .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
      .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
      .fft_valid(fft_valid), .freq(freq), .done(done), .busy(busy), .overrun(overrun)
`ifdef PEAK_MAG_EN
      , .peak_mag(peak_mag)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 16; i++) d[i] = '0;
   endtask

   // Drives fft_valid across one capture edge, returning just after it.
   task automatic send_frame();
      fft_valid = 1'b1;
      step();
      fft_valid = 1'b0;
   endtask

   // Steps until done is seen; cyc reports edges since capture (41 = timed out).
   task automatic wait_done(output int cyc, output int ovr);
      cyc = 0;
      ovr = 0;
      while (cyc <= 40) begin
         step();
         cyc++;
         if (overrun) ovr++;
         if (done) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tests++; if (freq !== 4'd0) begin fails++; $display("FAIL reset_freq: got %0d expected 0", freq); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`ifdef PEAK_MAG_EN
      tests++; if (peak_mag !== '0) begin fails++; $display("FAIL reset_peak_mag: got %0h expected 0", peak_mag); end
`endif
   endtask

   task automatic test_single();
      int cyc, ovr;
      clear_frame();
      d[5] = {16'h0300, 16'h0400};
      send_frame();
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
      clear_frame();
      wait_done(cyc, ovr);
      tests++; if (cyc != 16) begin fails++; $display("FAIL single_latency: got %0d expected 16", cyc); end
      tests++; if (freq !== 4'd5) begin fails++; $display("FAIL single_freq: got %0d expected 5", freq); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b expected 0", busy); end
`ifdef PEAK_MAG_EN
      tests++; if (peak_mag !== 33'h0_0019_0000) begin fails++; $display("FAIL single_peak_mag: got %0h expected 190000", peak_mag); end
`endif
      step();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_pulse: got %b expected 0", done); end
      tests++; if (freq !== 4'd5) begin fails++; $display("FAIL single_freq_hold: got %0d expected 5", freq); end
   endtask

   task automatic test_tie();
      int cyc, ovr;
      clear_frame();
      d[2] = {16'h0100, 16'h0000};
      d[9] = {16'h0100, 16'h0000};
      send_frame();
      wait_done(cyc, ovr);
      tests++; if (cyc != 16) begin fails++; $display("FAIL tie_latency: got %0d expected 16", cyc); end
      tests++; if (freq !== 4'd2) begin fails++; $display("FAIL tie_freq: got %0d expected 2", freq); end
   endtask

   task automatic test_most_negative();
      int cyc, ovr;
      for (int i = 0; i < 16; i++) d[i] = {16'h8000, 16'h8000};
      send_frame();
      clear_frame();
      wait_done(cyc, ovr);
      tests++; if (freq !== 4'd0) begin fails++; $display("FAIL neg_freq: got %0d expected 0", freq); end
`ifdef PEAK_MAG_EN
      tests++; if (peak_mag !== 33'h0_8000_0000) begin fails++; $display("FAIL neg_peak_mag: got %0h expected 80000000", peak_mag); end
`endif
   endtask

   task automatic test_back_to_back();
      int cyc, ovr, early;
      early = 0;
      ovr = 0;
      clear_frame();
      d[7] = {16'h0200, 16'hFE00};
      send_frame();
      clear_frame();
      for (int i = 1; i <= 15; i++) begin
         step();
         if (done) early++;
         if (overrun) ovr++;
      end
      d[12] = {16'h0000, 16'h0050};
      fft_valid = 1'b1;
      step();
      fft_valid = 1'b0;
      clear_frame();
      tests++; if (early != 0) begin fails++; $display("FAIL b2b_early_done: got %0d expected 0", early); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done1: got %b expected 1", done); end
      tests++; if (freq !== 4'd7) begin fails++; $display("FAIL b2b_freq1: got %0d expected 7", freq); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      wait_done(cyc, early);
      ovr += early;
      tests++; if (cyc != 16) begin fails++; $display("FAIL b2b_spacing: got %0d expected 16", cyc); end
      tests++; if (freq !== 4'd12) begin fails++; $display("FAIL b2b_freq2: got %0d expected 12", freq); end
      tests++; if (ovr != 0) begin fails++; $display("FAIL b2b_overrun: got %0d expected 0", ovr); end
   endtask

   task automatic test_overrun();
      int dones, ovrs, done_at, ovr_at;
      dones = 0; ovrs = 0; done_at = -1; ovr_at = -1;
      clear_frame();
      d[3] = {16'h0100, 16'h0100};
      send_frame();
      for (int i = 1; i <= 30; i++) begin
         if (i == 5) begin
            clear_frame();
            d[10] = {16'h7FFF, 16'h7FFF};
            fft_valid = 1'b1;
         end else begin
            fft_valid = 1'b0;
         end
         step();
         if (done) begin dones++; done_at = i; end
         if (overrun) begin ovrs++; ovr_at = i; end
      end
      clear_frame();
      tests++; if (ovrs != 1) begin fails++; $display("FAIL ovr_count: got %0d expected 1", ovrs); end
      tests++; if (ovr_at != 5) begin fails++; $display("FAIL ovr_cycle: got %0d expected 5", ovr_at); end
      tests++; if (dones != 1) begin fails++; $display("FAIL ovr_done_count: got %0d expected 1", dones); end
      tests++; if (done_at != 16) begin fails++; $display("FAIL ovr_done_cycle: got %0d expected 16", done_at); end
      tests++; if (freq !== 4'd3) begin fails++; $display("FAIL ovr_freq: got %0d expected 3", freq); end
   endtask

   task automatic test_reset_mid_scan();
      int cyc, ovr, dones;
      dones = 0;
      clear_frame();
      d[9] = {16'h0400, 16'h0000};
      send_frame();
      clear_frame();
      repeat (8) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++; if (freq !== 4'd0) begin fails++; $display("FAIL rstmid_freq: got %0d expected 0", freq); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      repeat (20) begin
         step();
         if (done) dones++;
      end
      tests++; if (dones != 0) begin fails++; $display("FAIL rstmid_aborted_done: got %0d expected 0", dones); end
      d[1] = {16'h0010, 16'hFFF0};
      send_frame();
      clear_frame();
      wait_done(cyc, ovr);
      tests++; if (cyc != 16) begin fails++; $display("FAIL rstmid_latency: got %0d expected 16", cyc); end
      tests++; if (freq !== 4'd1) begin fails++; $display("FAIL rstmid_freq2: got %0d expected 1", freq); end
   endtask

   initial begin
      clear_frame();
      test_reset();
      test_single();
      test_tie();
      test_most_negative();
      test_back_to_back();
      test_overrun();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
